// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demux scheduler: modes, channel indices, FSM encoding.
package demux_pkg;

    localparam int unsigned N_CH = 4;

    localparam logic MODE_TAGGED = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_FLUSH = ST_FLUSH
    } state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output holding register with valid/ready; data reads zero whenever empty.
module demux_chan_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] q_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load in the same cycle as a drain wins, keeping the channel valid without a gap.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/demux_scheduler.sv
// Routes an input word stream to four held channels by tag or strict round-robin,
// with drain-before-mode-change and single-cycle flush sequencing.
module demux_scheduler
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode_req,
    input  logic              flush,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] D,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [1:0]        sel,
    output logic              mode,
    output logic [CNT_W-1:0]  acc_count
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_c;
    logic             clr_c;
    logic [1:0]       tgt_c;
    logic [DATA_W-1:0] chan_data [N_CH];

    assign tgt_c = (mode_q == MODE_RR) ? rr_q : in_dest;
    assign clr_c = flush || (state_q == S_FLUSH);

    // Ready is combinational so a channel can refill in the cycle it drains.
    assign in_ready = rst_n && !flush && (state_q == S_RUN) &&
                      (!out_valid[tgt_c] || out_ready[tgt_c]);
    assign accept_c = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;

        if (accept_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mode_q == MODE_RR) begin
                rr_d = rr_q + 2'd1;
            end
        end

        unique case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (mode_req != mode_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (out_valid == '0) begin
                    mode_d  = mode_req;
                    rr_d    = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (mode_req != mode_q) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (clr_c) begin
            rr_d  = 2'd0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            mode_q  <= MODE_TAGGED;
            rr_q    <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr_c),
            .load_i  (accept_c && (tgt_c == 2'(i))),
            .data_i  (in_data),
            .ready_i (out_ready[i]),
            .valid_o (out_valid[i]),
            .q_o     (chan_data[i])
        );
    end

    assign A         = chan_data[CH_A];
    assign B         = chan_data[CH_B];
    assign C         = chan_data[CH_C];
    assign D         = chan_data[CH_D];
    assign sel       = tgt_c;
    assign mode      = mode_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: per-cycle vector table plus hand-written
// sequences for drain, flush and mid-stream reset.
module tb_demux_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic [1:0] in_dest;
    logic       in_valid;
    logic       in_ready;
    logic       mode_req;
    logic       flush;
    logic [3:0] A, B, C, D;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic       mode;
    logic [7:0] acc_count;

    int n_vec = 0;
    int n_mis = 0;

    demux_scheduler #(.DATA_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_req  (mode_req),
        .flush     (flush),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .mode      (mode),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic       vld;
        logic [3:0] data;
        logic [1:0] dest;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [1:0] e_sel;
        logic [3:0] e_ov;
        logic [3:0] e_a, e_b, e_c, e_d;
        logic [7:0] e_acc;
        logic       e_mode;
    } vec_t;

    localparam int unsigned N_VEC = 33;
    vec_t tbl [N_VEC];

    function automatic vec_t mk(logic mr, logic vld, logic [3:0] data, logic [1:0] dest,
                                logic [3:0] ordy, logic rdy, logic [1:0] s, logic [3:0] ov,
                                logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d,
                                logic [7:0] acc, logic m);
        vec_t v;
        v.mr = mr; v.vld = vld; v.data = data; v.dest = dest; v.ordy = ordy;
        v.e_rdy = rdy; v.e_sel = s; v.e_ov = ov;
        v.e_a = a; v.e_b = b; v.e_c = c; v.e_d = d;
        v.e_acc = acc; v.e_mode = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic mr, input logic vld, input logic [3:0] d,
                         input logic [1:0] dest, input logic [3:0] ordy);
        mode_req  = mr;
        in_valid  = vld;
        in_data   = d;
        in_dest   = dest;
        out_ready = ordy;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] ov, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                            input logic [7:0] acc);
        chk({tag, ".ov"},  32'(out_valid), 32'(ov));
        chk({tag, ".A"},   32'(A), 32'(a));
        chk({tag, ".B"},   32'(B), 32'(b));
        chk({tag, ".C"},   32'(C), 32'(c));
        chk({tag, ".D"},   32'(D), 32'(d));
        chk({tag, ".acc"}, 32'(acc_count), 32'(acc));
    endtask

    initial begin
        // Tests 1-2: tagged routing, hold/back-pressure, simultaneous channels
        tbl[0]  = mk(0,1,4'h5,2,4'hF, 1,2,4'h4, 0,0,5,0, 1,0);
        tbl[1]  = mk(0,1,4'hA,0,4'hF, 1,0,4'h1, 4'hA,0,0,0, 2,0);
        tbl[2]  = mk(0,0,4'h0,0,4'hF, 1,0,4'h0, 0,0,0,0, 2,0);
        tbl[3]  = mk(0,1,4'h3,1,4'hD, 1,1,4'h2, 0,3,0,0, 3,0);
        tbl[4]  = mk(0,1,4'h7,1,4'hD, 0,1,4'h2, 0,3,0,0, 3,0);
        tbl[5]  = mk(0,1,4'h7,1,4'hD, 0,1,4'h2, 0,3,0,0, 3,0);
        tbl[6]  = mk(0,1,4'h7,1,4'hF, 1,1,4'h2, 0,7,0,0, 4,0);
        tbl[7]  = mk(0,0,4'h0,1,4'hF, 1,1,4'h0, 0,0,0,0, 4,0);
        tbl[8]  = mk(0,1,4'h9,3,4'h0, 1,3,4'h8, 0,0,0,9, 5,0);
        tbl[9]  = mk(0,1,4'h6,0,4'h0, 1,0,4'h9, 6,0,0,9, 6,0);
        tbl[10] = mk(0,1,4'h2,3,4'h0, 0,3,4'h9, 6,0,0,9, 6,0);
        tbl[11] = mk(0,0,4'h0,0,4'hF, 1,0,4'h0, 0,0,0,0, 6,0);
        // Test 3: switch to RR from empty, one DRAIN cycle, then A,B,C,D,A,B
        tbl[12] = mk(1,0,4'h0,0,4'hF, 1,0,4'h0, 0,0,0,0, 6,0);
        tbl[13] = mk(1,0,4'h0,0,4'hF, 0,0,4'h0, 0,0,0,0, 6,1);
        tbl[14] = mk(1,1,4'h1,3,4'hF, 1,0,4'h1, 1,0,0,0, 7,1);
        tbl[15] = mk(1,1,4'h2,3,4'hF, 1,1,4'h2, 0,2,0,0, 8,1);
        tbl[16] = mk(1,1,4'h3,3,4'hF, 1,2,4'h4, 0,0,3,0, 9,1);
        tbl[17] = mk(1,1,4'h4,3,4'hF, 1,3,4'h8, 0,0,0,4, 10,1);
        tbl[18] = mk(1,1,4'h5,3,4'hF, 1,0,4'h1, 5,0,0,0, 11,1);
        tbl[19] = mk(1,1,4'h6,3,4'hF, 1,1,4'h2, 0,6,0,0, 12,1);
        tbl[20] = mk(1,0,4'h0,3,4'hF, 1,2,4'h0, 0,0,0,0, 12,1);
        // Test 4: C held; pointer comes back round to C and stalls instead of skipping to D
        tbl[21] = mk(1,1,4'hE,0,4'hF, 1,2,4'h4, 0,0,4'hE,0, 13,1);
        tbl[22] = mk(1,1,4'hF,0,4'hF, 1,3,4'h8, 0,0,0,4'hF, 14,1);
        tbl[23] = mk(1,1,4'h1,0,4'hB, 1,0,4'h1, 1,0,0,0, 15,1);
        tbl[24] = mk(1,1,4'h2,0,4'hB, 1,1,4'h2, 0,2,0,0, 16,1);
        tbl[25] = mk(1,1,4'h3,0,4'hB, 1,2,4'h4, 0,0,3,0, 17,1);
        tbl[26] = mk(1,1,4'h4,0,4'hB, 1,3,4'hC, 0,0,3,4, 18,1);
        tbl[27] = mk(1,1,4'h5,0,4'hB, 1,0,4'h5, 5,0,3,0, 19,1);
        tbl[28] = mk(1,1,4'h6,0,4'hB, 1,1,4'h6, 0,6,3,0, 20,1);
        tbl[29] = mk(1,1,4'h7,0,4'hB, 0,2,4'h4, 0,0,3,0, 20,1);
        tbl[30] = mk(1,1,4'h7,0,4'hB, 0,2,4'h4, 0,0,3,0, 20,1);
        tbl[31] = mk(1,1,4'h7,0,4'hF, 1,2,4'h4, 0,0,7,0, 21,1);
        tbl[32] = mk(1,0,4'h0,0,4'hF, 1,3,4'h0, 0,0,0,0, 21,1);

        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 0, 4'h0, 2'd0, 4'hF);

        // Reset values
        tick();
        chk("rst.rdy", 32'(in_ready), 32'd0);
        tick();
        chk_outs("rst", 4'h0, 0, 0, 0, 0, 8'd0);
        chk("rst.mode", 32'(mode), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(N_VEC); i++) begin
            drive(tbl[i].mr, tbl[i].vld, tbl[i].data, tbl[i].dest, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d.rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].e_sel));
            tick();
            chk_outs($sformatf("v%0d", i), tbl[i].e_ov, tbl[i].e_a, tbl[i].e_b,
                     tbl[i].e_c, tbl[i].e_d, tbl[i].e_acc);
            chk($sformatf("v%0d.mode", i), 32'(mode), 32'(tbl[i].e_mode));
        end

        // Test 5: hold A and D, request TAGGED, drain under stall, mode applies after empty
        drive(1, 1, 4'h9, 2'd0, 4'h0);
        #1 chk("t5.rdy0", 32'(in_ready), 32'd1);
        chk("t5.sel0", 32'(sel), 32'd3);
        tick();
        drive(1, 1, 4'hB, 2'd0, 4'h0);
        tick();
        chk_outs("t5.held", 4'h9, 4'hB, 0, 0, 4'h9, 8'd23);
        drive(0, 0, 4'h0, 2'd0, 4'h0);
        tick();
        chk("t5.mode_drain", 32'(mode), 32'd1);
        drive(0, 1, 4'h5, 2'd0, 4'h0);
        #1 chk("t5.rdy_drain", 32'(in_ready), 32'd0);
        drive(1, 1, 4'h5, 2'd0, 4'h0);
        tick();
        chk("t5.revert_mode", 32'(mode), 32'd1);
        drive(0, 1, 4'h5, 2'd0, 4'h1);
        #1 chk("t5.revert_rdy", 32'(in_ready), 32'd0);
        tick();
        chk_outs("t5.a_out", 4'h8, 0, 0, 0, 4'h9, 8'd23);
        drive(0, 1, 4'h5, 2'd0, 4'hF);
        #1 chk("t5.rdy_d", 32'(in_ready), 32'd0);
        tick();
        chk_outs("t5.empty", 4'h0, 0, 0, 0, 0, 8'd23);
        chk("t5.mode_late", 32'(mode), 32'd1);
        #1 chk("t5.rdy_late", 32'(in_ready), 32'd0);
        tick();
        chk("t5.mode_new", 32'(mode), 32'd0);
        chk("t5.acc", 32'(acc_count), 32'd23);
        #1 chk("t5.rdy_run", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        // Test 6a: flush with three channels valid and a word presented
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 4'(k + 1), 2'(k), 4'h0);
            tick();
        end
        chk_outs("t6.pre", 4'h7, 1, 2, 3, 0, 8'd26);
        drive(0, 1, 4'hF, 2'd3, 4'h0);
        flush = 1'b1;
        #1 chk("t6.rdy_flush", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk_outs("t6.post", 4'h0, 0, 0, 0, 0, 8'd0);
        #1 chk("t6.rdy_fstate", 32'(in_ready), 32'd0);
        tick();
        chk_outs("t6.after", 4'h0, 0, 0, 0, 0, 8'd0);
        #1 chk("t6.rdy_run", 32'(in_ready), 32'd1);

        // Test 6b: reset mid-stream
        drive(0, 1, 4'h4, 2'd1, 4'h0);
        tick();
        chk_outs("t6r.pre", 4'h2, 0, 4, 0, 0, 8'd1);
        drive(0, 1, 4'h6, 2'd2, 4'h0);
        rst_n = 1'b0;
        #1 chk("t6r.rdy", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 4'h0, 2'd0, 4'hF);
        chk_outs("t6r.post", 4'h0, 0, 0, 0, 0, 8'd0);
        chk("t6r.mode", 32'(mode), 32'd0);
        drive(0, 1, 4'h8, 2'd3, 4'hF);
        #1 chk("t6r.rdy_run", 32'(in_ready), 32'd1);
        tick();
        chk_outs("t6r.first", 4'h8, 0, 0, 0, 8, 8'd1);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
